// File: rtl/npu_fbuf_pkg.sv
`default_nettype none
// ============================================================================
// Module  : npu_fbuf_pkg -- bank state type, parameter defaults, bank wrap helper
// Revision: 1.0
// ============================================================================
package npu_fbuf_pkg;

    localparam int c_def_num_banks = 2;
    localparam int c_def_rows      = 64;
    localparam int c_def_row_bytes = 64;
    localparam int c_def_data_w    = 8;

    typedef enum logic [1:0] {
        BANK_EMPTY   = 2'd0,
        BANK_FILLING = 2'd1,
        BANK_FULL    = 2'd2
    } bank_state_t;

    function automatic int next_bank(input int idx, input int num_banks);
        return (idx + 1 >= num_banks) ? 0 : idx + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/npu_fbuf_bank_tracker.sv
`default_nettype none
// ============================================================================
// Module  : npu_fbuf_bank_tracker -- fill state and committed row count of one bank
// Revision: 1.0
// ============================================================================
module npu_fbuf_bank_tracker
    import npu_fbuf_pkg::*;
#(
    parameter int ROWS = c_def_rows,
    parameter int RW   = $clog2(ROWS + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_commit,
    input  logic          i_clear,
    output bank_state_t   o_state,
    output logic [RW-1:0] o_count
);

    localparam logic [RW-1:0] c_last_row = RW'(ROWS - 1);

    bank_state_t   r_state;
    bank_state_t   w_state_nxt;
    logic [RW-1:0] r_count;
    logic [RW-1:0] w_count_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= BANK_EMPTY;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
        end
    end

    // Clear beats commit: the reader releasing the bank discards any row landing with it.
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        if (i_clear) begin
            w_state_nxt = BANK_EMPTY;
            w_count_nxt = '0;
        end else if (i_commit && (r_state != BANK_FULL)) begin
            w_count_nxt = r_count + 1'b1;
            w_state_nxt = (r_count == c_last_row) ? BANK_FULL : BANK_FILLING;
        end
    end

    assign o_state = r_state;
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/npu_frame_buf_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : npu_frame_buf_ctrl -- multi-bank frame buffer handoff, CPU writer to NPU reader
// Revision: 1.0
// ============================================================================
module npu_frame_buf_ctrl
    import npu_fbuf_pkg::*;
#(
    parameter int NUM_BANKS = c_def_num_banks,
    parameter int ROWS      = c_def_rows,
    parameter int ROW_BYTES = c_def_row_bytes,
    parameter int DATA_W    = c_def_data_w
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              cpu_wr_i,
    input  logic [$clog2(ROWS*ROW_BYTES)-1:0] cpu_wr_addr_i,
    input  logic [DATA_W-1:0]                 cpu_wr_data_i,
    input  logic                              cpu_row_commit_p_i,
    input  logic [$clog2(ROWS+1)-1:0]         cpu_thrshld_i,
    input  logic                              err_clr_i,
    input  logic                              npu_done_p_i,
    output logic [NUM_BANKS-1:0]              mem_wr_en_o,
    output logic [$clog2(ROWS*ROW_BYTES)-1:0] mem_wr_addr_o,
    output logic [DATA_W-1:0]                 mem_wr_data_o,
    output logic [$clog2(NUM_BANKS)-1:0]      cpu_wr_bank_o,
    output logic [$clog2(ROWS+1)-1:0]         cpu_rows_written_o,
    output logic                              cpu_buf_full_o,
    output logic                              npu_start_p_o,
    output logic [$clog2(NUM_BANKS)-1:0]      npu_rd_bank_o,
    output logic [$clog2(ROWS+1)-1:0]         npu_rows_avail_o,
    output logic                              npu_active_o,
    output logic [2:0]                        err_o
);

    localparam int c_aw = $clog2(ROWS * ROW_BYTES);
    localparam int c_rw = $clog2(ROWS + 1);
    localparam int c_bw = $clog2(NUM_BANKS);
    localparam logic [c_rw-1:0] c_last_row = c_rw'(ROWS - 1);

    bank_state_t          w_state [NUM_BANKS];
    logic [c_rw-1:0]      w_count [NUM_BANKS];
    logic [NUM_BANKS-1:0] w_commit;
    logic [NUM_BANKS-1:0] w_clear;

    logic [c_bw-1:0]      r_wr_bank;
    logic [c_bw-1:0]      r_rd_bank;
    logic                 r_active;
    logic                 r_start;
    logic [NUM_BANKS-1:0] r_mem_wr_en;
    logic [c_aw-1:0]      r_mem_wr_addr;
    logic [DATA_W-1:0]    r_mem_wr_data;
    logic [2:0]           r_err;

    logic            w_buf_full;
    logic            w_wr_ok;
    logic            w_done_ok;
    logic            w_early_done;
    logic            w_commit_ok;
    logic            w_wr_advance;
    logic            w_rd_ready;
    logic            w_launch;
    logic [c_rw-1:0] w_thrshld;
    logic [2:0]      w_err_set;

    assign w_buf_full   = (w_state[r_wr_bank] == BANK_FULL);
    assign w_wr_ok      = cpu_wr_i && !w_buf_full;
    assign w_done_ok    = npu_done_p_i && r_active;
    assign w_early_done = w_done_ok && (w_state[r_rd_bank] != BANK_FULL);
    // A release of the writer's own bank wins over a row committed into it that cycle.
    assign w_commit_ok  = cpu_row_commit_p_i && !w_buf_full
                          && !(w_done_ok && (r_rd_bank == r_wr_bank));
    assign w_wr_advance = w_commit_ok && (w_count[r_wr_bank] == c_last_row);
    assign w_thrshld    = (cpu_thrshld_i == '0) ? c_rw'(1) : cpu_thrshld_i;
    assign w_rd_ready   = (w_count[r_rd_bank] >= w_thrshld) || (w_state[r_rd_bank] == BANK_FULL);
    assign w_launch     = !r_active && w_rd_ready;
    assign w_err_set    = {w_early_done, cpu_row_commit_p_i && w_buf_full, cpu_wr_i && w_buf_full};

    generate
        for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
            assign w_commit[gi] = w_commit_ok && (r_wr_bank == c_bw'(gi));
            assign w_clear[gi]  = w_done_ok && (r_rd_bank == c_bw'(gi));

            npu_fbuf_bank_tracker #(
                .ROWS (ROWS),
                .RW   (c_rw)
            ) u_tracker (
                .clk      (clk),
                .rst      (rst),
                .i_commit (w_commit[gi]),
                .i_clear  (w_clear[gi]),
                .o_state  (w_state[gi]),
                .o_count  (w_count[gi])
            );
        end
    endgenerate

    // An early release leaves the reader on the bank the writer restarts, keeping frame order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_bank     <= '0;
            r_rd_bank     <= '0;
            r_active      <= 1'b0;
            r_start       <= 1'b0;
            r_mem_wr_en   <= '0;
            r_mem_wr_addr <= '0;
            r_mem_wr_data <= '0;
            r_err         <= '0;
        end else begin
            r_mem_wr_en <= '0;
            if (w_wr_ok) begin
                r_mem_wr_en[r_wr_bank] <= 1'b1;
                r_mem_wr_addr          <= cpu_wr_addr_i;
                r_mem_wr_data          <= cpu_wr_data_i;
            end
            if (w_wr_advance) begin
                r_wr_bank <= c_bw'(next_bank(int'(r_wr_bank), NUM_BANKS));
            end
            if (w_done_ok) begin
                r_active <= 1'b0;
                if (!w_early_done) begin
                    r_rd_bank <= c_bw'(next_bank(int'(r_rd_bank), NUM_BANKS));
                end
            end else if (w_launch) begin
                r_active <= 1'b1;
            end
            r_start <= w_launch;
            r_err   <= (err_clr_i ? 3'b000 : r_err) | w_err_set;
        end
    end

    assign mem_wr_en_o        = r_mem_wr_en;
    assign mem_wr_addr_o      = r_mem_wr_addr;
    assign mem_wr_data_o      = r_mem_wr_data;
    assign cpu_wr_bank_o      = r_wr_bank;
    assign cpu_rows_written_o = w_count[r_wr_bank];
    assign cpu_buf_full_o     = w_buf_full;
    assign npu_start_p_o      = r_start;
    assign npu_rd_bank_o      = r_rd_bank;
    assign npu_rows_avail_o   = w_count[r_rd_bank];
    assign npu_active_o       = r_active;
    assign err_o              = r_err;

endmodule
`default_nettype wire

// File: tb/tb_npu_frame_buf_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_npu_frame_buf_ctrl -- 2-bank and 3-bank instances against a frame-level model
// Revision: 1.0
// ============================================================================
module tb_npu_frame_buf_ctrl;

    localparam int ROWS = 64;
    localparam int AW   = 12;
    localparam int RW   = 7;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cpu_wr = 1'b0;
    logic [AW-1:0] cpu_wr_addr = '0;
    logic [7:0]    cpu_wr_data = '0;
    logic          cpu_commit = 1'b0;
    logic [RW-1:0] thr = '0;
    logic          err_clr = 1'b0;
    logic          npu_done = 1'b0;

    logic [1:0]    d0_en;
    logic [AW-1:0] d0_addr;
    logic [7:0]    d0_data;
    logic [0:0]    d0_wrb;
    logic [RW-1:0] d0_rw;
    logic          d0_full;
    logic          d0_start;
    logic [0:0]    d0_rdb;
    logic [RW-1:0] d0_avail;
    logic          d0_act;
    logic [2:0]    d0_err;

    logic [2:0]    d1_en;
    logic [AW-1:0] d1_addr;
    logic [7:0]    d1_data;
    logic [1:0]    d1_wrb;
    logic [RW-1:0] d1_rw;
    logic          d1_full;
    logic          d1_start;
    logic [1:0]    d1_rdb;
    logic [RW-1:0] d1_avail;
    logic          d1_act;
    logic [2:0]    d1_err;

    always #5 clk = ~clk;

    npu_frame_buf_ctrl #(.NUM_BANKS(2), .ROWS(ROWS), .ROW_BYTES(64), .DATA_W(8)) dut_nb2 (
        .clk(clk), .rst(rst), .cpu_wr_i(cpu_wr), .cpu_wr_addr_i(cpu_wr_addr),
        .cpu_wr_data_i(cpu_wr_data), .cpu_row_commit_p_i(cpu_commit), .cpu_thrshld_i(thr),
        .err_clr_i(err_clr), .npu_done_p_i(npu_done), .mem_wr_en_o(d0_en),
        .mem_wr_addr_o(d0_addr), .mem_wr_data_o(d0_data), .cpu_wr_bank_o(d0_wrb),
        .cpu_rows_written_o(d0_rw), .cpu_buf_full_o(d0_full), .npu_start_p_o(d0_start),
        .npu_rd_bank_o(d0_rdb), .npu_rows_avail_o(d0_avail), .npu_active_o(d0_act),
        .err_o(d0_err)
    );

    npu_frame_buf_ctrl #(.NUM_BANKS(3), .ROWS(ROWS), .ROW_BYTES(64), .DATA_W(8)) dut_nb3 (
        .clk(clk), .rst(rst), .cpu_wr_i(cpu_wr), .cpu_wr_addr_i(cpu_wr_addr),
        .cpu_wr_data_i(cpu_wr_data), .cpu_row_commit_p_i(cpu_commit), .cpu_thrshld_i(thr),
        .err_clr_i(err_clr), .npu_done_p_i(npu_done), .mem_wr_en_o(d1_en),
        .mem_wr_addr_o(d1_addr), .mem_wr_data_o(d1_data), .cpu_wr_bank_o(d1_wrb),
        .cpu_rows_written_o(d1_rw), .cpu_buf_full_o(d1_full), .npu_start_p_o(d1_start),
        .npu_rd_bank_o(d1_rdb), .npu_rows_avail_o(d1_avail), .npu_active_o(d1_act),
        .err_o(d1_err)
    );

    // Status word: {wr_bank, rows_written, full, rd_bank, rows_avail, active, err}
    logic [22:0] d0_st, d1_st;
    logic [23:0] d0_wv, d1_wv;
    assign d0_st = {1'b0, d0_wrb, d0_rw, d0_full, 1'b0, d0_rdb, d0_avail, d0_act, d0_err};
    assign d1_st = {d1_wrb, d1_rw, d1_full, d1_rdb, d1_avail, d1_act, d1_err};
    assign d0_wv = {2'b00, d0_en, d0_addr, d0_data};
    assign d1_wv = {1'b0, d1_en, d1_addr, d1_data};

    int n_total = 0;
    int n_pass  = 0;

    // Frame-level model: rows per bank, writer/reader bank, reader ownership, sticky errors
    int         m_cnt [2][4];
    int         m_wr  [2];
    int         m_rd  [2];
    bit         m_act [2];
    bit [2:0]   m_err [2];
    logic [23:0] wq0[$], wq1[$];
    int          sq0[$], sq1[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [22:0] exp_status(input int k);
        return {2'(m_wr[k]), 7'(m_cnt[k][m_wr[k]]), m_cnt[k][m_wr[k]] == ROWS,
                2'(m_rd[k]), 7'(m_cnt[k][m_rd[k]]), m_act[k], m_err[k]};
    endfunction

    task automatic model_edge(input int k, input int nb);
        int th;
        bit full, start_now, done_ok, commit_ok, early;
        bit [2:0] set;
        logic [23:0] item;
        if (rst) begin
            for (int b = 0; b < 4; b++) m_cnt[k][b] = 0;
            m_wr[k] = 0; m_rd[k] = 0; m_act[k] = 1'b0; m_err[k] = 3'b000;
            return;
        end
        th        = (thr == 0) ? 1 : int'(thr);
        full      = (m_cnt[k][m_wr[k]] == ROWS);
        start_now = !m_act[k] && (m_cnt[k][m_rd[k]] >= th || m_cnt[k][m_rd[k]] == ROWS);
        done_ok   = npu_done && m_act[k];
        set       = 3'b000;
        commit_ok = 1'b0;
        early     = 1'b0;
        if (cpu_wr) begin
            if (full) set[0] = 1'b1;
            else begin
                item = {4'(1 << m_wr[k]), cpu_wr_addr, cpu_wr_data};
                if (k == 0) wq0.push_back(item); else wq1.push_back(item);
            end
        end
        if (cpu_commit) begin
            if (full) set[1] = 1'b1;
            else if (!(done_ok && m_rd[k] == m_wr[k])) commit_ok = 1'b1;
        end
        if (done_ok) begin
            early = (m_cnt[k][m_rd[k]] != ROWS);
            if (early) set[2] = 1'b1;
            m_cnt[k][m_rd[k]] = 0;
            m_act[k] = 1'b0;
            if (!early) m_rd[k] = (m_rd[k] + 1) % nb;
        end
        if (commit_ok) begin
            m_cnt[k][m_wr[k]]++;
            if (m_cnt[k][m_wr[k]] == ROWS) m_wr[k] = (m_wr[k] + 1) % nb;
        end
        if (err_clr) m_err[k] = 3'b000;
        m_err[k] |= set;
        if (start_now) begin
            m_act[k] = 1'b1;
            if (k == 0) sq0.push_back(m_rd[k]); else sq1.push_back(m_rd[k]);
        end
    endtask

    task automatic step();
        model_edge(0, 2);
        model_edge(1, 3);
        @(posedge clk);
        #1;
        chk("status_nb2", 64'(d0_st), 64'(exp_status(0)));
        chk("status_nb3", 64'(d1_st), 64'(exp_status(1)));
    endtask

    task automatic drive(input bit w, input bit c, input bit d, input bit e);
        cpu_wr      = w;
        cpu_wr_addr = AW'($urandom);
        cpu_wr_data = 8'($urandom);
        cpu_commit  = c;
        npu_done    = d;
        err_clr     = e;
        step();
    endtask

    always @(negedge clk) begin
        if (d0_en != '0) begin
            if (wq0.size() == 0) chk("wr_unexpected_nb2", 64'(d0_en), 64'd0);
            else chk("wr_nb2", 64'(d0_wv), 64'(wq0.pop_front()));
        end
        if (d1_en != '0) begin
            if (wq1.size() == 0) chk("wr_unexpected_nb3", 64'(d1_en), 64'd0);
            else chk("wr_nb3", 64'(d1_wv), 64'(wq1.pop_front()));
        end
        if (d0_start) begin
            if (sq0.size() == 0) chk("start_unexpected_nb2", 64'(d0_start), 64'd0);
            else chk("start_bank_nb2", 64'(d0_rdb), 64'(sq0.pop_front()));
        end
        if (d1_start) begin
            if (sq1.size() == 0) chk("start_unexpected_nb3", 64'(d1_start), 64'd0);
            else chk("start_bank_nb3", 64'(d1_rdb), 64'(sq1.pop_front()));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        // Reset state
        rst = 1'b1;
        thr = 7'd8;
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        chk("reset_outputs", 64'({d0_st, d0_en, d0_start}), 64'd0);
        rst = 1'b0;

        // Threshold start: 8 rows, pulse the cycle after count shows 8
        for (int i = 0; i < 8; i++) drive(1, 1, 0, 0);
        chk("thr_no_start_yet", 64'(d0_start), 64'd0);
        chk("thr_rows_avail", 64'(d0_avail), 64'd8);
        drive(0, 0, 0, 0);
        chk("thr_start_pulse", 64'(d0_start), 64'd1);
        chk("thr_start_bank", 64'(d0_rdb), 64'd0);

        // Fill bank0 then bank1 while bank0 is held
        for (int i = 0; i < 56; i++) drive(1, 1, 0, 0);
        chk("fill_wr_bank", 64'(d0_wrb), 64'd1);
        for (int i = 0; i < 64; i++) drive(0, 1, 0, 0);
        chk("full_flag", 64'(d0_full), 64'd1);
        chk("full_wr_wrapped", 64'(d0_wrb), 64'd0);
        drive(1, 0, 0, 0);
        chk("full_wr_err", 64'(d0_err), 64'b001);
        chk("full_wr_dropped", 64'(d0_en), 64'd0);
        drive(0, 1, 0, 0);
        chk("full_commit_err", 64'(d0_err), 64'b011);
        drive(0, 0, 0, 1);
        chk("err_clear", 64'(d0_err), 64'b000);
        drive(1, 0, 0, 1);
        chk("err_set_wins", 64'(d0_err), 64'b001);
        drive(0, 0, 0, 1);

        // Release full bank0, reader moves to bank1
        drive(0, 0, 1, 0);
        chk("rel_full_cleared", 64'(d0_full), 64'd0);
        chk("rel_rows_written", 64'(d0_rw), 64'd0);
        chk("rel_rd_bank", 64'(d0_rdb), 64'd1);
        drive(0, 0, 0, 0);
        chk("rel_next_start", 64'(d0_start), 64'd1);
        chk("rel_next_bank", 64'(d0_rdb), 64'd1);
        drive(0, 0, 1, 0);

        // Early done with a same-cycle commit
        thr = 7'd4;
        for (int i = 0; i < 10; i++) drive(1, 1, 0, 0);
        drive(0, 1, 1, 0);
        chk("early_err", 64'(d0_err), 64'b100);
        chk("early_rows_nb2", 64'(d0_rw), 64'd0);
        chk("early_rows_nb3", 64'(d1_rw), 64'd0);
        drive(0, 0, 0, 1);

        // Reset mid-frame
        for (int i = 0; i < 30; i++) drive(1, 1, 0, 0);
        rst = 1'b1;
        drive(1, 1, 0, 0);
        chk("midrst_status", 64'(d0_st), 64'd0);
        chk("midrst_mem", 64'({d0_en, d0_addr, d0_data, d0_start}), 64'd0);
        rst = 1'b0;
        drive(1, 0, 0, 0);
        chk("postrst_wr_bank0", 64'(d0_en), 64'b01);

        // Three-bank rotation over four frames
        thr = 7'd64;
        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < 64; i++) drive($urandom_range(0, 1) == 1, 1, 0, 0);
            got = 1'b0;
            for (int i = 0; i < 4 && !got; i++) begin
                drive(0, 0, 0, 0);
                if (d1_start) begin
                    got = 1'b1;
                    chk("rot_bank", 64'(d1_rdb), 64'(f % 3));
                end
            end
            chk("rot_start_seen", 64'(got), 64'd1);
            drive(0, 0, 1, 0);
        end
        chk("rot_no_err", 64'(d1_err), 64'd0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if (i % 400 == 0) thr = RW'($urandom_range(0, 70));
            rst = ($urandom_range(0, 999) == 0);
            drive($urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 59) == 0, $urandom_range(0, 49) == 0);
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 0);

        chk("drain_wr_nb2", 64'(wq0.size()), 64'd0);
        chk("drain_wr_nb3", 64'(wq1.size()), 64'd0);
        chk("drain_start_nb2", 64'(sq0.size()), 64'd0);
        chk("drain_start_nb3", 64'(sq1.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
